// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: FSM encodings,
// flush-length default and the NOP word loaded by flushed stages.
package pipe_ctrl_pkg;

    typedef enum logic {
        CTRL_RUN   = 1'b0,
        CTRL_FLUSH = 1'b1
    } ctrl_state_e;

    localparam int FLUSH_CYCLES_DEF = 2;

    // Wide enough for FLUSH_CYCLES-1 with FLUSH_CYCLES up to 3
    localparam int FCNT_W = 2;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter; increments on inc and sticks at all-ones.
module sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: hold/flush strobes for pc, if_id and id_ex, fetch
// redirect with extra fetch-kill cycles, deferred jumps across freezes.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              load_use_i,
    input  logic              mc_busy_i,
    input  logic              mem_wait_i,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              hold_id_ex_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              jump_en_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic              MULTI     = (FLUSH_CYCLES > 1);
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    ctrl_state_e       state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    logic              freeze;
    logic              hold_pc, hold_if_id, hold_id_ex;
    logic              flush_if_id, flush_id_ex, jump_en;
    logic [ADDR_W-1:0] jump_addr;

    assign freeze = mem_wait_i | mc_busy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CTRL_RUN;
            fcnt_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        hold_pc     = 1'b0;
        hold_if_id  = 1'b0;
        hold_id_ex  = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        jump_en     = 1'b0;
        jump_addr   = '0;

        if (freeze) begin
            // Whole front end stalls; a jump seen now is replayed later,
            // and only the first one survives.
            hold_pc    = 1'b1;
            hold_if_id = 1'b1;
            hold_id_ex = 1'b1;
            if (jump_en_i && !pend_q) begin
                pend_d      = 1'b1;
                pend_addr_d = jump_addr_i;
            end
        end else if (jump_en_i || pend_q) begin
            jump_en     = 1'b1;
            jump_addr   = pend_q ? pend_addr_q : jump_addr_i;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pend_d      = 1'b0;
            if (MULTI) begin
                state_d = CTRL_FLUSH;
                fcnt_d  = FCNT_LOAD;
            end else begin
                state_d = CTRL_RUN;
                fcnt_d  = '0;
            end
        end else if (state_q == CTRL_FLUSH) begin
            // Kill the words the synchronous ROM still delivers
            flush_if_id = 1'b1;
            if (fcnt_q <= FCNT_W'(1)) begin
                state_d = CTRL_RUN;
                fcnt_d  = '0;
            end else begin
                fcnt_d = fcnt_q - 1'b1;
            end
        end else if (load_use_i) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    // Outputs are forced low while reset is asserted, independent of inputs
    assign hold_pc_o     = hold_pc     & rst_n;
    assign hold_if_id_o  = hold_if_id  & rst_n;
    assign hold_id_ex_o  = hold_id_ex  & rst_n;
    assign flush_if_id_o = flush_if_id & rst_n;
    assign flush_id_ex_o = flush_id_ex & rst_n;
    assign jump_en_o     = jump_en     & rst_n;
    assign jump_addr_o   = jump_addr   & {ADDR_W{rst_n}};

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hold_pc_o),
        .count (stall_cnt_o)
    );

    sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (jump_en_o),
        .count (flush_cnt_o)
    );

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 5-stage core. It turns hazard and wait conditions from ID, EX and the LSU into per-register hold and flush strobes for the pc register, if_id and id_ex, and redirects fetch on jumps. It adds extra fetch-kill cycles to cover the synchronous instruction ROM, and defers jumps that arrive during a freeze. It also keeps saturating stall and redirect counters for performance debug.

## Interface
- ADDR_W, 32: width of instruction addresses.
- FLUSH_CYCLES, 2: cycles (1..3) that flush_if_id_o stays high after a redirect.
- CNT_W, 32: width of the performance counters.

- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous assert, active low
- jump_en_i  in  1  single-cycle pulse from EX: branch taken, jal or jalr
- jump_addr_i  in  ADDR_W  target address; valid while jump_en_i is high
- load_use_i  in  1  ID instruction needs the result of a load now in EX
- mc_busy_i  in  1  multi-cycle EX unit (divider) busy
- mem_wait_i  in  1  LSU data bus not ready
- hold_pc_o  out  1  pc register keeps its value
- hold_if_id_o  out  1  if_id keeps its contents
- hold_id_ex_o  out  1  id_ex keeps its contents
- flush_if_id_o  out  1  if_id loads INST_NOP and address 0
- flush_id_ex_o  out  1  id_ex loads a bubble
- jump_en_o  out  1  pc register loads jump_addr_o
- jump_addr_o  out  ADDR_W  redirect target
- stall_cnt_o  out  CNT_W  saturating count of cycles with hold_pc_o high
- flush_cnt_o  out  CNT_W  saturating count of cycles with jump_en_o high

## Operation
- freeze = mem_wait_i | mc_busy_i.
- Decision priority: freeze, then jump, then load_use.
- FSM states:
  - RUN
  - FLUSH: holds a down-counter fcnt.
  - Separately, a pending-jump flag pend with address register pend_addr.
- Freeze, in any state:
  - hold_pc_o, hold_if_id_o and hold_id_ex_o all 1.
  - Both flushes 0. jump_en_o 0.
  - fcnt does not change.
  - If jump_en_i arrives and pend=0: set pend and capture pend_addr. If pend=1: ignore jump_en_i (first jump wins).
- Jump, when not frozen and (jump_en_i or pend):
  - jump_en_o=1. jump_addr_o = pend ? pend_addr : jump_addr_i.
  - flush_if_id_o=1, flush_id_ex_o=1. All holds 0.
  - Clear pend.
  - If FLUSH_CYCLES>1: go to FLUSH with fcnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
  - load_use_i is ignored.
- FLUSH, not frozen, no jump:
  - flush_if_id_o=1. Other strobes 0.
  - fcnt decrements. Return to RUN when it reaches 1.
  - load_use_i is ignored, because the ID instruction is being killed.
  - A new jump in FLUSH reloads fcnt=FLUSH_CYCLES-1.
- Load-use, in RUN only, not frozen, no jump:
  - hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1 for the cycle.
- Otherwise (RUN, idle): all strobes 0. jump_addr_o = 0 when jump_en_o=0.
- Invariants, checkable every cycle:
  - hold_x and flush_x are never both 1 on the same register.
  - jump_en_o implies flush_if_id_o.
- Counters:
  - Each increments by 1 at the clock edge after its condition holds.
  - Each saturates at all-ones.

## Timing
- All strobe, jump and address outputs are combinational from the inputs plus registered state. Pipeline registers act on them at the next rising edge (zero added latency).
- Registered state: FSM, fcnt, pend, pend_addr, both counters. All update on the rising edge of clk.
- Reset (rst_n low) is asynchronous, including mid-operation:
  - State RUN, fcnt=0, pend=0, pend_addr=0, counters 0.
  - All outputs 0 while in reset.
- A deferred jump issues in the first cycle freeze is low. A jump_en_i pulse in that same cycle is ignored.
- Freeze and a jump in the same cycle: the freeze wins and the jump goes to pend.
- Freeze in the middle of FLUSH extends FLUSH by the length of the freeze. The number of flush cycles issued is unchanged.

## Structure
- defines.v holds:
  - CTRL_RUN / CTRL_FLUSH state encodings.
  - The FLUSH_CYCLES default.
  - The existing INST_NOP, which is used by the consumers.
- Sub-module sat_cnt (parameter W; inputs clk, rst_n, inc; output count), instantiated twice for the counters.
- The strobes go to the hold/flush inputs of the pc register, if_id and id_ex. jump_en_o / jump_addr_o go to the pc register.

## Test plan
- Reset held, then released, no inputs → all outputs 0. Counters stay 0 for 10 cycles.
- jump_en_i pulse with 0x0000_0100, FLUSH_CYCLES=2 →
  - Cycle 0: jump_en_o=1, jump_addr_o=0x100, both flushes 1.
  - Cycle 1: flush_if_id_o only.
  - Cycle 2: idle. flush_cnt_o=1.
- load_use_i for 1 cycle in RUN → hold_pc_o, hold_if_id_o and flush_id_ex_o high for 1 cycle. stall_cnt_o=1.
- mem_wait_i high 3 cycles, jump_en_i (0x200) in the first wait cycle and again (0x300) in the second →
  - 3 cycles of all holds, no flush.
  - Cycle 4: jump_en_o with 0x200. 0x300 is dropped.
  - stall_cnt_o=3.
- Jump, then mc_busy_i for 2 cycles during FLUSH, with load_use_i high throughout → flush_if_id_o appears exactly FLUSH_CYCLES times in total, and the load-use bubble appears only after return to RUN.
- rst_n low during FLUSH with pend=1 → outputs 0 immediately. After release: no stale jump, RUN, counters 0.
